// File: rtl/shear_sequencer_if.sv
// Bundles the shear sequencer's control, source-read and destination-write signals.
// master = sequencer side, slave = surrounding loader/writer/environment side.
interface shear_sequencer_if #(
    parameter int SRC_AW = 18
) ();
    logic              start;
    logic [7:0]        shear_x;
    logic [7:0]        shear_y;
    logic              busy;
    logic              done;
    logic [9:0]        out_rows;
    logic [9:0]        out_cols;
    logic              src_rd_en;
    logic [SRC_AW-1:0] src_addr;
    logic [7:0]        src_rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [19:0]       wr_addr;
    logic [7:0]        wr_data;

    modport master (
        input  start, shear_x, shear_y, src_rd_data, wr_ready,
        output busy, done, out_rows, out_cols, src_rd_en, src_addr,
               wr_valid, wr_addr, wr_data
    );

    modport slave (
        output start, shear_x, shear_y, src_rd_data, wr_ready,
        input  busy, done, out_rows, out_cols, src_rd_en, src_addr,
               wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/shear_sequencer.sv
// Image shear pass: zero-fill destination, then copy each source pixel to its sheared coordinate.
// 1 cycle per clear address, 2 cycles per pixel; a stalled write holds address/data until wr_ready.
module shear_sequencer #(
    parameter int ROWS   = 242,
    parameter int COLS   = 247,
    parameter int FRAC   = 8,
    parameter int SRC_AW = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    shear_sequencer_if.master bus
);
    localparam int         ACCW   = 18;
    localparam logic [9:0] LAST_I = 10'(ROWS - 1);
    localparam logic [9:0] LAST_J = 10'(COLS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RD, WR, FIN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        sx_q, sx_d, sy_q, sy_d;
    logic [9:0]        out_rows_q, out_rows_d, out_cols_q, out_cols_d;
    logic [9:0]        cr_q, cr_d, cc_q, cc_d;
    logic [9:0]        i_q, i_d, j_q, j_d;
    logic [ACCW-1:0]   ox_acc_q, ox_acc_d, oy_acc_q, oy_acc_d;
    logic [SRC_AW-1:0] src_addr_q, src_addr_d;
    logic [7:0]        pix_q, pix_d;
    logic              rd_dly_q, rd_dly_d;

    logic [19:0]       ext_r, ext_c;
    logic [10:0]       dst_row, dst_col;
    logic              in_bounds;

    logic              busy, done, rd_en, wr_vld;
    logic [19:0]       wr_adr;
    logic [7:0]        wr_dat;

    // Output size is multiplied once per pass; per-pixel offsets come from accumulators.
    assign ext_r     = 20'(COLS) * 20'(bus.shear_y);
    assign ext_c     = 20'(ROWS) * 20'(bus.shear_x);
    assign dst_row   = 11'(i_q) + 11'(oy_acc_q >> FRAC);
    assign dst_col   = 11'(j_q) + 11'(ox_acc_q >> FRAC);
    assign in_bounds = (dst_row < {1'b0, out_rows_q}) && (dst_col < {1'b0, out_cols_q});

    always_comb begin
        state_d    = state_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        out_rows_d = out_rows_q;
        out_cols_d = out_cols_q;
        cr_d       = cr_q;
        cc_d       = cc_q;
        i_d        = i_q;
        j_d        = j_q;
        ox_acc_d   = ox_acc_q;
        oy_acc_d   = oy_acc_q;
        src_addr_d = src_addr_q;
        rd_dly_d   = (state_q == RD);
        // Read data is only valid the cycle after RD; keep a copy for stalled writes.
        pix_d      = rd_dly_q ? bus.src_rd_data : pix_q;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        wr_vld     = 1'b0;
        wr_adr     = '0;
        wr_dat     = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = CLEAR;
                    sx_d       = bus.shear_x;
                    sy_d       = bus.shear_y;
                    out_rows_d = 10'(ROWS) + 10'(ext_r >> FRAC);
                    out_cols_d = 10'(COLS) + 10'(ext_c >> FRAC);
                    cr_d       = '0;
                    cc_d       = '0;
                    i_d        = '0;
                    j_d        = '0;
                    ox_acc_d   = '0;
                    oy_acc_d   = '0;
                    src_addr_d = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                wr_vld = 1'b1;
                wr_adr = {cr_q, cc_q};
                if (bus.wr_ready) begin
                    if (cc_q == out_cols_q - 10'd1) begin
                        cc_d = '0;
                        if (cr_q == out_rows_q - 10'd1) begin
                            cr_d    = '0;
                            state_d = RD;
                        end else begin
                            cr_d = cr_q + 10'd1;
                        end
                    end else begin
                        cc_d = cc_q + 10'd1;
                    end
                end
            end
            RD: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                state_d = WR;
            end
            WR: begin
                busy   = 1'b1;
                wr_vld = in_bounds;
                wr_adr = {dst_row[9:0], dst_col[9:0]};
                wr_dat = rd_dly_q ? bus.src_rd_data : pix_q;
                // Out-of-frame targets are skipped without a handshake.
                if (bus.wr_ready || !in_bounds) begin
                    src_addr_d = src_addr_q + 1'b1;
                    state_d    = RD;
                    if (j_q == LAST_J) begin
                        j_d      = '0;
                        oy_acc_d = '0;
                        ox_acc_d = ox_acc_q + ACCW'(sx_q);
                        if (i_q == LAST_I) begin
                            state_d = FIN;
                        end else begin
                            i_d = i_q + 10'd1;
                        end
                    end else begin
                        j_d      = j_q + 10'd1;
                        oy_acc_d = oy_acc_q + ACCW'(sy_q);
                    end
                end
            end
            FIN: begin
                done       = 1'b1;
                src_addr_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sx_q       <= '0;
            sy_q       <= '0;
            out_rows_q <= '0;
            out_cols_q <= '0;
            cr_q       <= '0;
            cc_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            ox_acc_q   <= '0;
            oy_acc_q   <= '0;
            src_addr_q <= '0;
            pix_q      <= '0;
            rd_dly_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            out_rows_q <= out_rows_d;
            out_cols_q <= out_cols_d;
            cr_q       <= cr_d;
            cc_q       <= cc_d;
            i_q        <= i_d;
            j_q        <= j_d;
            ox_acc_q   <= ox_acc_d;
            oy_acc_q   <= oy_acc_d;
            src_addr_q <= src_addr_d;
            pix_q      <= pix_d;
            rd_dly_q   <= rd_dly_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.out_rows  = out_rows_q;
    assign bus.out_cols  = out_cols_q;
    assign bus.src_rd_en = rd_en;
    assign bus.src_addr  = src_addr_q;
    assign bus.wr_valid  = wr_vld;
    assign bus.wr_addr   = wr_adr;
    assign bus.wr_data   = wr_dat;
endmodule
